// File: rtl/fm_stream_pkg.sv
// Shared types for the feature-map streamer: FSM states, output FIFO entry and read tag.
package fm_stream_pkg;

  localparam int unsigned PIX_W = 8;
  // Frame dimension width: 255 plus an optional 2-pixel border still fits.
  localparam int unsigned DIM_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
    logic             eof;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  // Travels one cycle beside each issued pixel; rd=0 marks a zero border pixel.
  typedef struct packed {
    logic valid;
    logic rd;
    logic sof;
    logic eol;
    logic eof;
  } rd_tag_t;

endpackage

// File: rtl/stream_out_fifo.sv
// Show-ahead synchronous FIFO holding pixel+marker entries, with occupancy count.
module stream_out_fifo
  import fm_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fifo_entry_t                  wr_entry,
  input  logic                         pop,
  output fifo_entry_t                  rd_entry,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);

  always_comb begin
    rd_entry = '0;
    if (!empty) rd_entry = fifo_entry_t'(mem_q[rd_ptr]);
  end

endmodule

// File: rtl/feature_map_streamer.sv
// Raster streamer: reads a feature map from 1-cycle SRAM and emits it on valid/ready with sof/eol/eof.
// Optional zero-border frame when built with STREAM_ZERO_PAD_EN.
module feature_map_streamer
  import fm_stream_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        img_width,
  input  logic [7:0]        img_height,
  input  logic [ADDR_W-1:0] base_addr,
`ifdef STREAM_ZERO_PAD_EN
  input  logic              pad_en,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  fsm_state_e        state, state_d;
  logic [DIM_W-1:0]  fw_q, fh_q, col, row;
  logic [ADDR_W-1:0] ptr;
  logic              pad_q, pad_c;
  rd_tag_t           tag_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, pop_c, issue_c, border_c, credit_c;
  logic              last_col_c, last_row_c, zero_c;
  fifo_entry_t       push_entry, head;

`ifdef STREAM_ZERO_PAD_EN
  assign pad_c = pad_en;
`else
  assign pad_c = 1'b0;
`endif

  assign zero_c     = (img_width == 8'd0) || (img_height == 8'd0);
  assign last_col_c = (col == fw_q - DIM_W'(1));
  assign last_row_c = (row == fh_q - DIM_W'(1));
  assign border_c   = pad_q && ((row == '0) || last_row_c || (col == '0) || last_col_c);
  assign pop_c      = valid_out && ready_in;
  // A slot is free if the FIFO plus the returning item fits, counting this cycle's pop.
  assign credit_c   = (OCC_W'(fifo_count) + OCC_W'(tag_q.valid)) <
                      (OCC_W'(FIFO_DEPTH) + OCC_W'(pop_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Empty frames pass through DRAIN, which exits at once with nothing outstanding.
  always_comb begin
    state_d   = state;
    issue_c   = 1'b0;
    mem_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = zero_c ? DRAIN : RUN;
      end
      RUN: begin
        issue_c   = credit_c;
        mem_rd_en = credit_c && !border_c;
        if (credit_c && last_col_c && last_row_c) state_d = DRAIN;
      end
      DRAIN: begin
        if (!tag_q.valid &&
            ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop_c)))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame geometry, raster position, address pointer and the one-cycle tag stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw_q  <= '0;
      fh_q  <= '0;
      col   <= '0;
      row   <= '0;
      ptr   <= '0;
      pad_q <= 1'b0;
      tag_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy  <= (state_d == RUN) || (state_d == DRAIN);
      done  <= (state_d == DONE);
      tag_q <= '0;
      if (state == IDLE && start) begin
        pad_q <= pad_c;
        fw_q  <= DIM_W'(img_width)  + (pad_c ? DIM_W'(2) : DIM_W'(0));
        fh_q  <= DIM_W'(img_height) + (pad_c ? DIM_W'(2) : DIM_W'(0));
        col   <= '0;
        row   <= '0;
        ptr   <= base_addr;
      end else if (issue_c) begin
        tag_q <= '{valid: 1'b1,
                   rd:    !border_c,
                   sof:   (row == '0) && (col == '0),
                   eol:   last_col_c,
                   eof:   last_row_c && last_col_c};
        if (!border_c) ptr <= ptr + ADDR_W'(1);
        if (last_col_c) begin
          col <= '0;
          row <= row + DIM_W'(1);
        end else begin
          col <= col + DIM_W'(1);
        end
      end
    end
  end

  assign mem_addr = ptr;

  always_comb begin
    push_entry      = '0;
    push_entry.data = tag_q.rd ? mem_rd_data : '0;
    push_entry.sof  = tag_q.sof;
    push_entry.eol  = tag_q.eol;
    push_entry.eof  = tag_q.eof;
  end

  stream_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_q.valid),
    .wr_entry (push_entry),
    .pop      (pop_c),
    .rd_entry (head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign valid_out = !fifo_empty;
  assign data_out  = head.data;
  assign sof       = head.sof;
  assign eol       = head.eol;
  assign eof       = head.eof;

endmodule

// File: tb/tb_feature_map_streamer.sv
// Scoreboard bench for feature_map_streamer: frame model fills an expected-beat queue, a monitor checks the stream.
module tb_feature_map_streamer;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        img_width = '0;
  logic [7:0]        img_height = '0;
  logic [ADDR_W-1:0] base_addr = '0;
`ifdef STREAM_ZERO_PAD_EN
  logic              pad_en = 1'b0;
`endif
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data = '0;
  logic [7:0]        data_out;
  logic              valid_out;
  logic              ready_in = 1'b1;
  logic              sof, eol, eof, busy, done;

  feature_map_streamer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .img_width(img_width), .img_height(img_height), .base_addr(base_addr),
`ifdef STREAM_ZERO_PAD_EN
    .pad_en(pad_en),
`endif
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM, one-cycle read latency.
  logic [7:0] sram [65536];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= sram[mem_addr];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [10:0] exp_q [$];
  int rd_total = 0, acc_total = 0, frames_done = 0, beats_seen = 0;
  int first_acc = 0, last_acc = 0, done_exp = -1;
  logic prev_stall = 1'b0;
  logic [10:0] prev_beat = '0, got, want;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: ready_in = 1'b1;
      1: ready_in = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: ready_in = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the expected queue on every handshake and checks stalls, credit and done timing.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
      rd_total   = 0;
      acc_total  = 0;
    end else begin
      got = {data_out, sof, eol, eof};
      if (prev_stall) begin
        n_cmp++;
        if (!valid_out || got !== prev_beat) begin
          n_bad++;
          $display("FAIL stall_hold @%0d: valid=%0b beat=%h, required valid=1 beat=%h",
                   cyc, valid_out, got, prev_beat);
        end
      end
      if (mem_rd_en) begin
        n_cmp++;
        if (rd_total - acc_total - int'(valid_out && ready_in) >= int'(DEPTH)) begin
          n_bad++;
          $display("FAIL read_credit @%0d: outstanding=%0d, required < %0d",
                   cyc, rd_total - acc_total - int'(valid_out && ready_in), DEPTH);
        end
      end
      if (valid_out && ready_in) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat @%0d: got %h, required no beat", cyc, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_bad++;
            $display("FAIL beat @%0d: got data=%h sof/eol/eof=%b, required data=%h sof/eol/eof=%b",
                     cyc, got[10:3], got[2:0], want[10:3], want[2:0]);
          end
          if (want[0] && exp_q.size() == 0) done_exp = cyc + 1;
        end
        if (beats_seen == 0) first_acc = cyc;
        last_acc = cyc;
        beats_seen++;
        acc_total++;
      end
      if (mem_rd_en) rd_total++;
      if (done) begin
        n_cmp++;
        if (cyc != done_exp) begin
          n_bad++;
          $display("FAIL done_timing: got done at cycle %0d, required cycle %0d", cyc, done_exp);
        end
        frames_done++;
      end
      prev_stall = valid_out && !ready_in;
      prev_beat  = got;
    end
  end

  // Reference frame: row-major over the (optionally bordered) geometry, address base + r*W + c mod 2^16.
  task automatic push_expected(input int w, input int h, input logic [15:0] base, input bit pad);
    int p, fw, fh;
    logic [15:0] a;
    logic [7:0] v;
    logic s, el, ef, brd;
    p  = pad ? 1 : 0;
    fw = w + 2 * p;
    fh = h + 2 * p;
    if (w == 0 || h == 0) return;
    for (int r = 0; r < fh; r++) begin
      for (int c = 0; c < fw; c++) begin
        brd = pad && (r == 0 || r == fh - 1 || c == 0 || c == fw - 1);
        a   = 16'(int'(base) + (r - p) * w + (c - p));
        v   = brd ? 8'h00 : sram[a];
        s   = (r == 0) && (c == 0);
        el  = (c == fw - 1);
        ef  = (r == fh - 1) && (c == fw - 1);
        exp_q.push_back({v, s, el, ef});
      end
    end
  endtask

  task automatic pulse_start(input int w, input int h, input logic [15:0] base, input bit pad);
    @(posedge clk);
    #1;
    img_width  = 8'(w);
    img_height = 8'(h);
    base_addr  = base;
`ifdef STREAM_ZERO_PAD_EN
    pad_en     = pad;
`endif
    start      = 1'b1;
    if (w == 0 || h == 0) done_exp = cyc + 2;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_done(input int f0, input string name);
    int i;
    i = 0;
    while (frames_done == f0 && i < 3000) begin
      @(posedge clk);
      i++;
    end
    check_int({name, "_done_seen"}, frames_done - f0, 1);
  endtask

  task automatic run_frame(input int w, input int h, input logic [15:0] base,
                           input bit pad, input int rmode, input string name);
    int f0, r0, p;
    p = pad ? 1 : 0;
    ready_mode = rmode;
    push_expected(w, h, base, pad);
    f0 = frames_done;
    r0 = rd_total;
    beats_seen = 0;
    pulse_start(w, h, base, pad);
    wait_done(f0, name);
    check_int({name, "_leftover"}, exp_q.size(), 0);
    check_int({name, "_reads"}, rd_total - r0, w * h);
    if (rmode == 0 && w > 0 && h > 0)
      check_int({name, "_back_to_back"}, last_acc - first_acc, (w + 2 * p) * (h + 2 * p) - 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    logic [40:0] v;
    v = {mem_rd_en, mem_addr, data_out, valid_out, sof, eol, eof, busy, done};
    n_cmp++;
    if (v !== '0) begin
      n_bad++;
      $display("FAIL %s: outputs=%h, required all zero", name, v);
    end
  endtask

  task automatic fill_rand(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) sram[16'(int'(base) + i)] = 8'($urandom);
  endtask

  initial begin
    int w, h, f0;
    logic [15:0] b;
    for (int i = 0; i < 12; i++) sram[16'(16'h0100 + i)] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_values");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(4, 3, 16'h0100, 1'b0, 0, "ramp_4x3");
    run_frame(4, 3, 16'h0100, 1'b0, 1, "ramp_4x3_stall");
    run_frame(0, 5, 16'h0100, 1'b0, 0, "zero_width");
    run_frame(3, 0, 16'h0100, 1'b0, 0, "zero_height");
    sram[16'h0200] = 8'hF9;
    run_frame(1, 1, 16'h0200, 1'b0, 0, "single_pixel");
    fill_rand(16'h0400, 5);
    run_frame(1, 5, 16'h0400, 1'b0, 2, "one_column");
    fill_rand(16'hFFFE, 6);
    run_frame(3, 2, 16'hFFFE, 1'b0, 2, "addr_wrap");

    // Abort after 5 accepted pixels; no done may follow, then a clean restart.
    ready_mode = 0;
    push_expected(4, 3, 16'h0100, 1'b0);
    beats_seen = 0;
    f0 = frames_done;
    pulse_start(4, 3, 16'h0100, 1'b0);
    for (int i = 0; i < 100 && beats_seen < 5; i++) @(posedge clk);
    check_int("abort_reached_5_beats", int'(beats_seen >= 5), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort_outputs");
    exp_q.delete();
    done_exp = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    check_int("abort_no_done", frames_done - f0, 0);
    run_frame(4, 3, 16'h0100, 1'b0, 0, "restart_4x3");

    for (int k = 0; k < 6; k++) begin
      w = int'($urandom_range(1, 7));
      h = int'($urandom_range(1, 7));
      b = 16'($urandom);
      fill_rand(b, w * h);
      run_frame(w, h, b, 1'b0, 2, "random");
    end

`ifdef STREAM_ZERO_PAD_EN
    sram[16'h0300] = 8'd1;
    sram[16'h0301] = 8'd2;
    sram[16'h0302] = 8'd3;
    sram[16'h0303] = 8'd4;
    run_frame(2, 2, 16'h0300, 1'b1, 0, "pad_2x2");
    fill_rand(16'h0500, 12);
    run_frame(4, 3, 16'h0500, 1'b1, 2, "pad_random");
    run_frame(4, 3, 16'h0500, 1'b0, 2, "pad_off");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule
